// File: rtl/key_trigger_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_trigger_conditioner
// Description : N-channel push-button conditioner. Raw active-low keys are
//               synchronised, debounced by a per-channel four-state FSM, and
//               turned into a held level plus fixed-width press and release
//               pulses.
// Ports       : fifty_MHz_clock - system clock, rising edge
//               reset           - synchronous, active-high
//               key_n           - raw keys, 0 = pressed, asynchronous
//               channel_enable  - per-channel enable, 0 holds channel idle
//               trigger_level   - debounced key-held level
//               press_pulse     - PULSE_CYCLES-wide pulse on accepted press
//               release_pulse   - PULSE_CYCLES-wide pulse on accepted release
//               any_press       - OR of press_pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_trigger_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int PULSE_CYCLES    = 1
) (
    input  logic                fifty_MHz_clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_KEYS-1:0] channel_enable,
    output logic [NUM_KEYS-1:0] trigger_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic                any_press
);

    localparam logic [1:0] c_st_idle         = 2'd0;
    localparam logic [1:0] c_st_press_wait   = 2'd1;
    localparam logic [1:0] c_st_pressed      = 2'd2;
    localparam logic [1:0] c_st_release_wait = 2'd3;

    // Debounce exits on compare-equal, so the counter can never wrap.
    localparam logic [CNT_W-1:0] c_deb_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    // Two-flop synchroniser. Flops reset to 1 (released) so that leaving
    // reset with a key held still requires a full debounce.
    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] w_pressed;

    always_ff @(posedge fifty_MHz_clock) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_channel
            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             r_level;
            logic             w_level_nxt;
            logic             r_press;
            logic             w_press_nxt;
            logic             r_release;
            logic             w_release_nxt;
            logic [CNT_W-1:0] r_pcnt;
            logic [CNT_W-1:0] w_pcnt_nxt;
            logic             w_start_press;
            logic             w_start_release;

            always_ff @(posedge fifty_MHz_clock) begin
                if (reset) begin
                    r_state   <= c_st_idle;
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_pcnt    <= '0;
                end else begin
                    r_state   <= w_state_nxt;
                    r_cnt     <= w_cnt_nxt;
                    r_level   <= w_level_nxt;
                    r_press   <= w_press_nxt;
                    r_release <= w_release_nxt;
                    r_pcnt    <= w_pcnt_nxt;
                end
            end

            always_comb begin
                w_state_nxt     = r_state;
                w_cnt_nxt       = r_cnt;
                w_level_nxt     = r_level;
                w_start_press   = 1'b0;
                w_start_release = 1'b0;

                case (r_state)
                    c_st_idle: begin
                        if (w_pressed[g]) begin
                            w_state_nxt = c_st_press_wait;
                            w_cnt_nxt   = c_one;
                        end
                    end
                    c_st_press_wait: begin
                        if (!w_pressed[g]) begin
                            w_state_nxt = c_st_idle;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == c_deb_last) begin
                            w_state_nxt   = c_st_pressed;
                            w_cnt_nxt     = '0;
                            w_level_nxt   = 1'b1;
                            w_start_press = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + c_one;
                        end
                    end
                    c_st_pressed: begin
                        if (!w_pressed[g]) begin
                            w_state_nxt = c_st_release_wait;
                            w_cnt_nxt   = c_one;
                        end
                    end
                    c_st_release_wait: begin
                        if (w_pressed[g]) begin
                            // Short release glitch: back to held, no new press.
                            w_state_nxt = c_st_pressed;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == c_deb_last) begin
                            w_state_nxt     = c_st_idle;
                            w_cnt_nxt       = '0;
                            w_level_nxt     = 1'b0;
                            w_start_release = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + c_one;
                        end
                    end
                    default: begin
                        w_state_nxt = c_st_idle;
                        w_cnt_nxt   = '0;
                    end
                endcase

                // Disabled channel collapses to idle with nothing emitted.
                if (!channel_enable[g]) begin
                    w_state_nxt     = c_st_idle;
                    w_cnt_nxt       = '0;
                    w_level_nxt     = 1'b0;
                    w_start_press   = 1'b0;
                    w_start_release = 1'b0;
                end
            end

            // One pulse counter serves both pulses: press and release are
            // separated by at least a full debounce, so they never overlap.
            always_comb begin
                w_press_nxt   = r_press;
                w_release_nxt = r_release;
                w_pcnt_nxt    = r_pcnt;

                if (r_press || r_release) begin
                    if (r_pcnt == c_pulse_last) begin
                        w_press_nxt   = 1'b0;
                        w_release_nxt = 1'b0;
                        w_pcnt_nxt    = '0;
                    end else begin
                        w_pcnt_nxt = r_pcnt + c_one;
                    end
                end

                if (w_start_press) begin
                    w_press_nxt = 1'b1;
                    w_pcnt_nxt  = '0;
                end
                if (w_start_release) begin
                    w_release_nxt = 1'b1;
                    w_pcnt_nxt    = '0;
                end

                if (!channel_enable[g]) begin
                    w_press_nxt   = 1'b0;
                    w_release_nxt = 1'b0;
                    w_pcnt_nxt    = '0;
                end
            end

            assign trigger_level[g] = r_level;
            assign press_pulse[g]   = r_press;
            assign release_pulse[g] = r_release;
        end
    endgenerate

    assign any_press = |press_pulse;

endmodule
`default_nettype wire
